// File: rtl/intersect_sphere_seq_pkg.sv
// Shared definitions for the sequential ray/sphere intersect unit.
//  W_DEF / FRAC_DEF : default operand width and fraction bits (Q16.16)
//  MAC_STEPS        : products issued by the shared multiplier per ray
//  state_t          : controller states
//  sqrt_iters()     : restoring-sqrt iteration count for a Q(W-FRAC).FRAC
//                     result taken from a 2*FRAC-scaled radicand
package intersect_sphere_seq_pkg;

  localparam int W_DEF     = 32;
  localparam int FRAC_DEF  = 16;
  localparam int MAC_STEPS = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_CHECK,
    S_SQRT,
    S_FINAL,
    S_REJECT
  } state_t;

  // Radicand is W+FRAC bits wide; two radicand bits are consumed per iteration.
  function automatic int sqrt_iters(input int w, input int frac);
    return (w + frac) / 2;
  endfunction

endpackage

// File: rtl/intersect_sphere_seq_if.sv
// Request/result bundle for intersect_sphere_seq.
//  master : requester side (drives start and the ray/sphere operands)
//  slave  : intersect unit side (drives busy/done and the results)
//  Operands and results are W-bit signed Q(W-FRAC).FRAC values.
interface intersect_sphere_seq_if #(
  parameter int W = intersect_sphere_seq_pkg::W_DEF
);
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] radius_sqr;
  logic [W-1:0] center_x, center_y, center_z;
  logic [W-1:0] orig_x, orig_y, orig_z;
  logic [W-1:0] dir_x, dir_y, dir_z;
  logic [W-1:0] t0, t1, t_near;
  logic         hit;

  modport master (
    output start, radius_sqr, center_x, center_y, center_z,
           orig_x, orig_y, orig_z, dir_x, dir_y, dir_z,
    input  busy, done, t0, t1, t_near, hit
  );

  modport slave (
    input  start, radius_sqr, center_x, center_y, center_z,
           orig_x, orig_y, orig_z, dir_x, dir_y, dir_z,
    output busy, done, t0, t1, t_near, hit
  );
endinterface

// File: rtl/intersect_sphere_seq_isqrt.sv
// isqrt_seq: iterative restoring integer square root, two radicand bits per
// cycle, N/2 cycles per result.
//  clk, rst_n : clock, asynchronous active-low reset
//  start      : load radicand (ignored bookkeeping-wise while running)
//  radicand   : N-bit unsigned input, N even
//  done       : one-cycle pulse, root valid (root holds afterwards)
//  root       : floor(sqrt(radicand)), N/2 bits
module isqrt_seq #(
  parameter int N = 48
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   radicand,
  output logic           done,
  output logic [N/2-1:0] root
);
  localparam int H  = N / 2;
  localparam int CW = $clog2(H + 1);

  logic [H-1:0]  rem;
  logic [N-1:0]  rad_sh;
  logic [CW-1:0] cnt;

  logic [H-1:0]  src_rem, src_root, rem_n, root_n;
  logic [1:0]    src_bits;
  logic [H+1:0]  cur, trial;
  logic          ge;

  // The first iteration runs in the load cycle straight from the radicand, so
  // the remaining H-1 iterations plus the done pulse fill exactly H cycles.
  // Intermediate remainders stay below 2^H; only the discarded final one can
  // exceed it.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_root = start ? '0 : root;
    src_bits = start ? radicand[N-1:N-2] : rad_sh[N-1:N-2];
    cur      = {src_rem, src_bits};
    trial    = {src_root, 2'b01};
    ge       = (cur >= trial);
    rem_n    = H'(ge ? (cur - trial) : cur);
    root_n   = H'({src_root, ge});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      root   <= '0;
      rad_sh <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem    <= rem_n;
        root   <= root_n;
        rad_sh <= N'({radicand, 2'b00});
        cnt    <= CW'(H - 1);
      end else if (cnt != '0) begin
        rem    <= rem_n;
        root   <= root_n;
        rad_sh <= N'({rad_sh, 2'b00});
        cnt    <= cnt - CW'(1);
        done   <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/intersect_sphere_seq.sv
// intersect_sphere_seq: sequential ray/sphere intersection.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave side of intersect_sphere_seq_if
//               start/busy/done handshake, radius_sqr, center_*, orig_*,
//               dir_* in; t0, t1, t_near, hit out (held until next done)
// One shared W x W signed multiplier produces seven products over seven MAC
// cycles; an iterative sqrt yields thc. Latency is fixed per path: done in
// cycle 10 on reject and cycle 10+ITERS on hit, counted from the start cycle.
module intersect_sphere_seq
  import intersect_sphere_seq_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int FRAC        = FRAC_DEF,
  parameter bit CULL_BEHIND = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  intersect_sphere_seq_if.slave bus
);
  localparam int ITERS = sqrt_iters(W, FRAC);
  localparam int RW    = 2 * ITERS;
  localparam int PW    = 2 * W;
  localparam int AW    = 2 * W + 2;

  state_t              state;
  logic [2:0]          step;
  logic signed [W-1:0] r2, cx, cy, cz, ox, oy, oz, dx, dy, dz;
  logic signed [W-1:0] lx, ly, lz, tca;
  logic signed [AW-1:0] acc, ll, d2;

  logic signed [W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext, acc_sum, r2e;
  logic                 miss, sq_start, sq_done;
  logic [ITERS-1:0]     sq_root;
  logic [RW-1:0]        rad;
  logic signed [W-1:0]  thc, t0_n, t1_n, tn_n;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (step)
      3'd0:    begin mul_a = lx;  mul_b = dx;  end
      3'd1:    begin mul_a = ly;  mul_b = dy;  end
      3'd2:    begin mul_a = lz;  mul_b = dz;  end
      3'd3:    begin mul_a = lx;  mul_b = lx;  end
      3'd4:    begin mul_a = ly;  mul_b = ly;  end
      3'd5:    begin mul_a = lz;  mul_b = lz;  end
      default: begin mul_a = tca; mul_b = tca; end
    endcase
    prod     = PW'(mul_a) * PW'(mul_b);
    prod_ext = AW'(prod);
    acc_sum  = acc + prod_ext;

    // ll and d2 sit at 2*FRAC scale, so r^2 is lifted to match.
    r2e      = AW'(r2) <<< FRAC;
    miss     = (d2 > r2e) || (tca[W-1] && (CULL_BEHIND || (ll > r2e)));
    rad      = RW'(r2e - d2);
    sq_start = (state == S_CHECK) && !miss;

    thc  = W'(sq_root);
    t0_n = tca - thc;
    t1_n = tca + thc;
    tn_n = t0_n[W-1] ? t1_n : t0_n;
  end

  isqrt_seq #(.N(RW)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sq_start),
    .radicand (rad),
    .done     (sq_done),
    .root     (sq_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= '0;
      r2         <= '0;
      cx         <= '0;
      cy         <= '0;
      cz         <= '0;
      ox         <= '0;
      oy         <= '0;
      oz         <= '0;
      dx         <= '0;
      dy         <= '0;
      dz         <= '0;
      lx         <= '0;
      ly         <= '0;
      lz         <= '0;
      tca        <= '0;
      acc        <= '0;
      ll         <= '0;
      d2         <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.hit    <= 1'b0;
      bus.t0     <= '0;
      bus.t1     <= '0;
      bus.t_near <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            r2       <= bus.radius_sqr;
            cx       <= bus.center_x;
            cy       <= bus.center_y;
            cz       <= bus.center_z;
            ox       <= bus.orig_x;
            oy       <= bus.orig_y;
            oz       <= bus.orig_z;
            dx       <= bus.dir_x;
            dy       <= bus.dir_y;
            dz       <= bus.dir_z;
            bus.busy <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          lx    <= cx - ox;
          ly    <= cy - oy;
          lz    <= cz - oz;
          acc   <= '0;
          step  <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          // acc is reused: dot product in steps 0-2, |L|^2 in steps 3-5.
          step <= step + 3'd1;
          case (step)
            3'd2: begin
              tca <= W'(acc_sum >>> FRAC);
              acc <= '0;
            end
            3'd5: ll <= acc_sum;
            3'(MAC_STEPS - 1): begin
              d2    <= ll - prod_ext;
              state <= S_CHECK;
            end
            default: acc <= acc_sum;
          endcase
        end
        S_CHECK: begin
          if (miss) begin
            bus.t0     <= '0;
            bus.t1     <= '0;
            bus.t_near <= '0;
            bus.hit    <= 1'b0;
            bus.done   <= 1'b1;
            state      <= S_REJECT;
          end else begin
            state <= S_SQRT;
          end
        end
        S_SQRT: begin
          if (sq_done) begin
            bus.t0     <= t0_n;
            bus.t1     <= t1_n;
            bus.t_near <= tn_n;
            bus.hit    <= ~tn_n[W-1];
            bus.done   <= 1'b1;
            state      <= S_FINAL;
          end
        end
        S_FINAL, S_REJECT: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intersect_sphere_seq.sv
// Bench for intersect_sphere_seq: two instances (CULL_BEHIND 0 and 1) share
// the same stimulus; an arithmetic model predicts latency and results.
module tb_intersect_sphere_seq;
  localparam int W     = 32;
  localparam int FRAC  = 16;
  localparam int ITERS = (W + FRAC) / 2;
  localparam int TMO   = 80;

  typedef struct {
    logic [31:0] t0, t1, tn;
    logic        hit;
    int          lat;
  } res_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] r2 = '0, cx = '0, cy = '0, cz = '0, ox = '0, oy = '0, oz = '0;
  logic [31:0] dx = '0, dy = '0, dz = '0;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   start_cyc = 0;
  bit   pending[2] = '{0, 0};
  bit   have_res[2] = '{0, 0};
  res_t exp_r[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  intersect_sphere_seq_if #(.W(W)) bus0 ();
  intersect_sphere_seq_if #(.W(W)) bus1 ();

  assign bus0.start = start;  assign bus1.start = start;
  assign bus0.radius_sqr = r2; assign bus1.radius_sqr = r2;
  assign bus0.center_x = cx;  assign bus1.center_x = cx;
  assign bus0.center_y = cy;  assign bus1.center_y = cy;
  assign bus0.center_z = cz;  assign bus1.center_z = cz;
  assign bus0.orig_x = ox;    assign bus1.orig_x = ox;
  assign bus0.orig_y = oy;    assign bus1.orig_y = oy;
  assign bus0.orig_z = oz;    assign bus1.orig_z = oz;
  assign bus0.dir_x = dx;     assign bus1.dir_x = dx;
  assign bus0.dir_y = dy;     assign bus1.dir_y = dy;
  assign bus0.dir_z = dz;     assign bus1.dir_z = dz;

  intersect_sphere_seq #(.W(W), .FRAC(FRAC), .CULL_BEHIND(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  intersect_sphere_seq #(.W(W), .FRAC(FRAC), .CULL_BEHIND(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [31:0] o_t0[2], o_t1[2], o_tn[2];
  logic        o_hit[2], o_done[2], o_busy[2];
  assign o_t0[0] = bus0.t0;     assign o_t0[1] = bus1.t0;
  assign o_t1[0] = bus0.t1;     assign o_t1[1] = bus1.t1;
  assign o_tn[0] = bus0.t_near; assign o_tn[1] = bus1.t_near;
  assign o_hit[0] = bus0.hit;   assign o_hit[1] = bus1.hit;
  assign o_done[0] = bus0.done; assign o_done[1] = bus1.done;
  assign o_busy[0] = bus0.busy; assign o_busy[1] = bus1.busy;

  function automatic logic signed [127:0] sx(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return s;
  endfunction

  // Plain-arithmetic reference: geometric formulas on wide integers.
  function automatic res_t model(input logic [31:0] r2v, cxv, cyv, czv, oxv, oyv, ozv,
                                 dxv, dyv, dzv, input bit cull);
    res_t r;
    logic signed [127:0] lx, ly, lz, dot, ll, tca, d2, r2e, rad, x, cand;
    logic signed [31:0]  tca32, thc32, t0, t1, tn;
    lx    = sx(cxv - oxv);
    ly    = sx(cyv - oyv);
    lz    = sx(czv - ozv);
    dot   = lx * sx(dxv) + ly * sx(dyv) + lz * sx(dzv);
    tca32 = 32'(dot >>> FRAC);
    tca   = tca32;
    ll    = lx * lx + ly * ly + lz * lz;
    d2    = ll - tca * tca;
    r2e   = sx(r2v) * (128'sd1 <<< FRAC);
    if (d2 > r2e || (tca < 0 && (cull || ll > r2e))) begin
      r.t0 = '0; r.t1 = '0; r.tn = '0; r.hit = 1'b0; r.lat = 10;
    end else begin
      rad = (r2e - d2) & ((128'sd1 <<< (W + FRAC)) - 1);
      x = '0;
      for (int b = ITERS - 1; b >= 0; b--) begin
        cand = x + (128'sd1 <<< b);
        if (cand * cand <= rad) x = cand;
      end
      thc32 = 32'(x);
      t0 = tca32 - thc32;
      t1 = tca32 + thc32;
      tn = (t0 < 0) ? t1 : t0;
      r.t0 = t0; r.t1 = t1; r.tn = tn; r.hit = (tn >= 0); r.lat = 10 + ITERS;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s[dut%0d] @cyc %0d: got %h, want %h", name, idx, cyc, act, want);
    end
  endtask

  // Per-cycle compare against the model prediction.
  always @(negedge clk) begin
    bit due;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_busy", i, 32'(o_busy[i]), 32'd0);
        chk("rst_done", i, 32'(o_done[i]), 32'd0);
        chk("rst_hit",  i, 32'(o_hit[i]),  32'd0);
        chk("rst_t0",   i, o_t0[i], 32'd0);
        chk("rst_t1",   i, o_t1[i], 32'd0);
        chk("rst_tn",   i, o_tn[i], 32'd0);
      end else begin
        due = pending[i] && (cyc == start_cyc + exp_r[i].lat);
        chk("done", i, 32'(o_done[i]), 32'(due));
        chk("busy", i, 32'(o_busy[i]), 32'(pending[i] && cyc > start_cyc));
        if (due || (!pending[i] && have_res[i])) begin
          chk("t0",     i, o_t0[i], exp_r[i].t0);
          chk("t1",     i, o_t1[i], exp_r[i].t1);
          chk("t_near", i, o_tn[i], exp_r[i].tn);
          chk("hit",    i, 32'(o_hit[i]), 32'(exp_r[i].hit));
        end
        if (due) begin
          pending[i]  = 1'b0;
          have_res[i] = 1'b1;
        end
      end
    end
  end

  task automatic launch(input logic [31:0] r2v, cxv, cyv, czv, oxv, oyv, ozv,
                        dxv, dyv, dzv);
    @(negedge clk);
    r2 = r2v; cx = cxv; cy = cyv; cz = czv; ox = oxv; oy = oyv; oz = ozv;
    dx = dxv; dy = dyv; dz = dzv;
    exp_r[0]  = model(r2v, cxv, cyv, czv, oxv, oyv, ozv, dxv, dyv, dzv, 1'b0);
    exp_r[1]  = model(r2v, cxv, cyv, czv, oxv, oyv, ozv, dxv, dyv, dzv, 1'b1);
    start_cyc = cyc;
    pending   = '{1, 1};
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((pending[0] || pending[1]) && n < TMO) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic lit(input string name, input int i, input logic [31:0] et0, et1, etn,
                     input logic eh);
    chk({name, "_t0"},  i, o_t0[i], et0);
    chk({name, "_t1"},  i, o_t1[i], et1);
    chk({name, "_tn"},  i, o_tn[i], etn);
    chk({name, "_hit"}, i, 32'(o_hit[i]), 32'(eh));
  endtask

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] R2  = 32'h0004_0000;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: plain hit
    launch(R2, 0, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c1", i, 32'h0008_0000, 32'h000C_0000, 32'h0008_0000, 1'b1);

    // 2: miss by distance, restarted right after the previous done
    launch(R2, 32'h0005_0000, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c2", i, 0, 0, 0, 1'b0);

    // 3: tangent
    launch(R2, 32'h0002_0000, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c3", i, 32'h000A_0000, 32'h000A_0000, 32'h000A_0000, 1'b1);

    // 4: origin at center, tca = 0
    launch(R2, 0, 0, 0, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c4", i, 32'hFFFE_0000, 32'h0002_0000, 32'h0002_0000, 1'b1);

    // 5: sphere behind, origin outside
    launch(R2, 0, 0, 32'hFFF6_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c5", i, 0, 0, 0, 1'b0);

    // inside sphere with tca < 0: only the legacy cull rejects it
    launch(R2, 0, 0, 32'hFFFF_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    lit("in", 0, 32'hFFFD_0000, 32'h0001_0000, 32'h0001_0000, 1'b1);
    lit("in", 1, 0, 0, 0, 1'b0);

    // off-axis ray and origin, model only
    launch(32'h0001_8000, 32'h0003_0000, 32'h0004_0000, 32'h0000_8000,
           ONE, 0, 0, 32'h0000_9999, 32'h0000_CCCC, 0);
    wait_done();

    // 6a: starts while busy are ignored, inputs changed after accept
    launch(R2, 0, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    while (cyc < start_cyc + 5) @(negedge clk);
    start = 1'b1; cx = 32'h0005_0000;
    @(negedge clk);
    start = 1'b0;
    while (cyc < start_cyc + 20) @(negedge clk);
    start = 1'b1; cz = 32'hFFF6_0000;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 2; i++) lit("c6a", i, 32'h0008_0000, 32'h000C_0000, 32'h0008_0000, 1'b1);
    repeat (5) @(negedge clk);

    // 6b: reset mid-operation aborts, then a clean rerun
    launch(R2, 0, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    while (cyc < start_cyc + 15) @(negedge clk);
    #2 rst_n = 1'b0;
    pending  = '{0, 0};
    have_res = '{0, 0};
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 2; i++) lit("c6b_rst", i, 0, 0, 0, 1'b0);
    launch(R2, 0, 0, 32'h000A_0000, 0, 0, 0, 0, 0, ONE);
    wait_done();
    for (int i = 0; i < 2; i++) lit("c6b", i, 32'h0008_0000, 32'h000C_0000, 32'h0008_0000, 1'b1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
